// File: rtl/dea_pkg.sv
// Purpose : shared types and constants for the DEA streaming cipher core.
// Contents: FSM state enum, mode encodings.
package dea_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      KEYLOAD = 2'd1,
      RUN     = 2'd2
   } state_e;

   localparam logic MODE_XOR   = 1'b0;
   localparam logic MODE_CHAIN = 1'b1;

endpackage

// File: rtl/dea_stream_core_if.sv
// Purpose : streaming handshake bundle between a word source/sink and the DEA core.
// Signals : kset, mode, din_valid, din, dout_ready (source/sink -> core);
//           din_ready, dout_valid, dout (core -> source/sink).
// Modports: master = source/sink side, slave = core side.
interface dea_stream_core_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic              kset;
   logic              mode;
   logic              din_valid;
   logic [DATA_W-1:0] din;
   logic              din_ready;
   logic              dout_valid;
   logic [DATA_W-1:0] dout;
   logic              dout_ready;

   modport master (
      output kset, mode, din_valid, din, dout_ready,
      input  din_ready, dout_valid, dout
   );

   modport slave (
      input  kset, mode, din_valid, din, dout_ready,
      output din_ready, dout_valid, dout
   );

endinterface

// File: rtl/dea_key_ram.sv
// Purpose : key register file, one synchronous write port, one combinational read port.
// Ports   : i_clk clock; i_we/i_wptr/i_wdata write port; i_kidx read address;
//           o_rdata key word at i_kidx.
module dea_key_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned AW     = 4
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_wptr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_kidx,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Key contents are only meaningful after a commit, so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_kidx];

endmodule

// File: rtl/dea_stream_core.sv
// Purpose : streaming DEA cipher: serial multi-word key load, then one word per clock
//           XOR (mode 0) or cipher-chained XOR (mode 1) with a rolling key index.
// Ports   : dclk clock; reset synchronous active-high;
//           bus (slave) valid/ready stream in and out, plus kset/mode controls;
//           key_len number of committed key words; key_ovf sticky key overflow flag.
module dea_stream_core
   import dea_pkg::*;
#(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned MAX_KEY_WORDS = 16,
   parameter int unsigned KIDX_W        = $clog2(MAX_KEY_WORDS) + 1
) (
   input  logic              dclk,
   input  logic              reset,
   dea_stream_core_if.slave  bus,
   output logic [KIDX_W-1:0] key_len,
   output logic              key_ovf
);

   localparam int unsigned AW = (MAX_KEY_WORDS > 1) ? $clog2(MAX_KEY_WORDS) : 1;

   state_e              r_state;
   logic [KIDX_W-1:0]   r_wptr;
   logic [KIDX_W-1:0]   r_kidx;
   logic [KIDX_W-1:0]   r_key_len;
   logic [DATA_W-1:0]   r_chain;
   logic [DATA_W-1:0]   r_dout;
   logic                r_dout_valid;
   logic                r_key_ovf;

   logic                w_din_ready;
   logic                w_accept;
   logic                w_enter_kl;
   logic                w_wptr_full;
   logic                w_key_we;
   logic                w_encrypt;
   logic [AW-1:0]       w_waddr;
   logic [DATA_W-1:0]   w_key_word;
   logic [DATA_W-1:0]   w_cipher;

   // Input readiness per state; in RUN a stalled output blocks new words.
   always_comb begin
      w_din_ready = 1'b0;
      case (r_state)
         IDLE:    w_din_ready = bus.kset;
         KEYLOAD: w_din_ready = 1'b1;
         RUN:     w_din_ready = !r_dout_valid || bus.dout_ready;
         default: w_din_ready = 1'b0;
      endcase
   end

   assign w_accept    = bus.din_valid && w_din_ready;
   assign w_enter_kl  = bus.kset && (r_state != KEYLOAD);
   assign w_wptr_full = (r_wptr == KIDX_W'(MAX_KEY_WORDS));
   assign w_encrypt   = (r_state == RUN) && !bus.kset && w_accept;

   // A word taken on the kset rising cycle is key[0]; stale wptr is ignored then.
   assign w_key_we = w_accept && bus.kset && (w_enter_kl || !w_wptr_full);
   assign w_waddr  = w_enter_kl ? '0 : r_wptr[AW-1:0];

   assign w_cipher = bus.din ^ w_key_word ^ ((bus.mode == MODE_CHAIN) ? r_chain : '0);

   dea_key_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_KEY_WORDS),
      .AW     (AW)
   ) u_key_ram (
      .i_clk   (dclk),
      .i_we    (w_key_we),
      .i_wptr  (w_waddr),
      .i_wdata (bus.din),
      .i_kidx  (r_kidx[AW-1:0]),
      .o_rdata (w_key_word)
   );

   // FSM, key/stream counters and output register.
   always_ff @(posedge dclk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_wptr       <= '0;
         r_kidx       <= '0;
         r_key_len    <= '0;
         r_chain      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_key_ovf    <= 1'b0;
      end else begin
         // Pending output drains in every state, including during a rekey.
         if (w_encrypt) begin
            r_dout       <= w_cipher;
            r_dout_valid <= 1'b1;
         end else if (bus.dout_ready) begin
            r_dout_valid <= 1'b0;
         end

         if (w_enter_kl) begin
            r_state   <= KEYLOAD;
            r_wptr    <= w_accept ? KIDX_W'(1) : '0;
            r_kidx    <= '0;
            r_chain   <= '0;
            r_key_ovf <= 1'b0;
         end else begin
            case (r_state)
               IDLE: ;
               KEYLOAD: begin
                  if (bus.kset) begin
                     if (w_accept) begin
                        if (w_wptr_full) r_key_ovf <= 1'b1;
                        else             r_wptr    <= r_wptr + KIDX_W'(1);
                     end
                  end else begin
                     // Commit; a data word offered on this cycle has no key yet and is dropped.
                     r_key_len <= r_wptr;
                     r_state   <= (r_wptr == '0) ? IDLE : RUN;
                  end
               end
               RUN: begin
                  if (w_encrypt) begin
                     if (r_kidx == r_key_len - KIDX_W'(1)) r_kidx <= '0;
                     else                                  r_kidx <= r_kidx + KIDX_W'(1);
                     if (bus.mode != MODE_XOR) r_chain <= w_cipher;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.din_ready  = w_din_ready;
   assign bus.dout_valid = r_dout_valid;
   assign bus.dout       = r_dout;
   assign key_len        = r_key_len;
   assign key_ovf        = r_key_ovf;

endmodule

// File: tb/tb_dea_stream_core.sv
// Purpose : directed, scoreboard-based bench for dea_stream_core (MAX_KEY_WORDS=4).
module tb_dea_stream_core;

   localparam int unsigned DW = 8;
   localparam int unsigned KW = 3;

   logic          dclk;
   logic          reset;
   logic [KW-1:0] key_len;
   logic          key_ovf;

   dea_stream_core_if #(.DATA_W(DW)) bus ();

   dea_stream_core #(
      .DATA_W        (DW),
      .MAX_KEY_WORDS (4)
   ) dut (
      .dclk    (dclk),
      .reset   (reset),
      .bus     (bus),
      .key_len (key_len),
      .key_ovf (key_ovf)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   logic [DW-1:0] q_exp[$];
   int            n_cmp = 0;
   int            n_err = 0;
   bit            acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge (output consumption, input acceptance), return #1 after posedge.
   task automatic tick();
      @(negedge dclk);
      acc = (bus.din_valid === 1'b1) && (bus.din_ready === 1'b1);
      if ((bus.dout_valid === 1'b1) && (bus.dout_ready === 1'b1)) begin
         n_cmp++;
         assert (q_exp.size() > 0) else begin
            n_err++;
            $error("FAIL dout_unexpected observed=%0h expected=none", bus.dout);
         end
         if (q_exp.size() > 0) chk("dout", 32'(bus.dout), 32'(q_exp.pop_front()));
      end
      @(posedge dclk);
      #1;
   endtask

   task automatic send(input logic k, input logic m, input logic [DW-1:0] d,
                       input bit push, input logic [DW-1:0] e);
      bus.kset      = k;
      bus.mode      = m;
      bus.din       = d;
      bus.din_valid = 1'b1;
      if (push) q_exp.push_back(e);
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) tick();
      chk("accept_timeout", 32'(acc), 32'd1);
      bus.din_valid = 1'b0;
   endtask

   task automatic commit(input logic [KW-1:0] exp_len);
      bus.kset      = 1'b0;
      bus.din_valid = 1'b0;
      tick();
      chk("key_len", 32'(key_len), 32'(exp_len));
   endtask

   task automatic drain();
      bus.din_valid = 1'b0;
      for (int i = 0; i < 20 && q_exp.size() > 0; i++) tick();
      tick();
      tick();
      chk("drain_left", 32'(q_exp.size()), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      bus.kset       = 1'b0;
      bus.mode       = 1'b0;
      bus.din_valid  = 1'b0;
      bus.din        = '0;
      bus.dout_ready = 1'b1;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout",       32'(bus.dout),       32'd0);
      chk("rst_key_len",    32'(key_len),        32'd0);
      chk("rst_key_ovf",    32'(key_ovf),        32'd0);
      chk("rst_din_ready",  32'(bus.din_ready),  32'd0);

      // Test 1: key AA x4, plain XOR.
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 8'hAA, 1'b0, 8'h00);
      commit(3'd4);
      send(1'b0, 1'b0, 8'h48, 1'b1, 8'hE2);
      send(1'b0, 1'b0, 8'h65, 1'b1, 8'hCF);
      send(1'b0, 1'b0, 8'h6C, 1'b1, 8'hC6);
      drain();

      // Test 2: key 01,02,03, index wrap.
      send(1'b1, 1'b0, 8'h01, 1'b0, 8'h00);
      send(1'b1, 1'b0, 8'h02, 1'b0, 8'h00);
      send(1'b1, 1'b0, 8'h03, 1'b0, 8'h00);
      commit(3'd3);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h03);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h01);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
      drain();

      // Test 3: chained mode, key 0F.
      send(1'b1, 1'b0, 8'h0F, 1'b0, 8'h00);
      commit(3'd1);
      send(1'b0, 1'b1, 8'h01, 1'b1, 8'h0E);
      send(1'b0, 1'b1, 8'h02, 1'b1, 8'h03);
      send(1'b0, 1'b1, 8'h03, 1'b1, 8'h0F);
      drain();

      // Test 4: key overflow at depth 4; old key_len held until commit.
      send(1'b1, 1'b0, 8'h11, 1'b0, 8'h00);
      send(1'b1, 1'b0, 8'h22, 1'b0, 8'h00);
      send(1'b1, 1'b0, 8'h33, 1'b0, 8'h00);
      send(1'b1, 1'b0, 8'h44, 1'b0, 8'h00);
      chk("ovf_before_5th", 32'(key_ovf), 32'd0);
      send(1'b1, 1'b0, 8'h55, 1'b0, 8'h00);
      chk("ovf_after_5th",  32'(key_ovf), 32'd1);
      chk("key_len_held",   32'(key_len), 32'd1);
      commit(3'd4);
      chk("ovf_sticky", 32'(key_ovf), 32'd1);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h22);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h33);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h44);
      send(1'b0, 1'b0, 8'h00, 1'b1, 8'h11);

      // Test 5: backpressure mid-stream (kidx continues at 1).
      send(1'b0, 1'b0, 8'h01, 1'b1, 8'h23);
      send(1'b0, 1'b0, 8'h02, 1'b1, 8'h31);
      bus.din        = 8'h03;
      bus.din_valid  = 1'b1;
      bus.dout_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_dout_valid", 32'(bus.dout_valid), 32'd1);
         chk("bp_dout",       32'(bus.dout),       32'h31);
         chk("bp_din_ready",  32'(bus.din_ready),  32'd0);
      end
      bus.dout_ready = 1'b1;
      send(1'b0, 1'b0, 8'h03, 1'b1, 8'h47);
      send(1'b0, 1'b0, 8'h04, 1'b1, 8'h15);
      drain();

      // Test 6a: rekey in the cycle after a chained word; that word becomes key[0].
      send(1'b0, 1'b1, 8'h05, 1'b1, 8'h27);
      send(1'b1, 1'b0, 8'h5A, 1'b0, 8'h00);
      commit(3'd1);
      chk("ovf_cleared", 32'(key_ovf), 32'd0);
      send(1'b0, 1'b1, 8'h01, 1'b1, 8'h5B);
      send(1'b0, 1'b1, 8'h02, 1'b1, 8'h03);
      send(1'b0, 1'b0, 8'h07, 1'b1, 8'h5D);

      // Test 6b: rekey while output is stalled; pending word drains afterwards.
      bus.dout_ready = 1'b0;
      bus.kset       = 1'b1;
      tick();
      chk("rk_dout_valid", 32'(bus.dout_valid), 32'd1);
      chk("rk_dout",       32'(bus.dout),       32'h5D);
      chk("rk_din_ready",  32'(bus.din_ready),  32'd1);
      send(1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
      chk("rk_dout_hold", 32'(bus.dout), 32'h5D);
      bus.dout_ready = 1'b1;
      commit(3'd1);
      send(1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
      drain();

      // Reset with a pending output: that output is lost.
      bus.dout_ready = 1'b0;
      send(1'b0, 1'b0, 8'h11, 1'b0, 8'h00);
      chk("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.dout_ready = 1'b1;
      chk("mid_rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("mid_rst_dout",       32'(bus.dout),       32'd0);
      chk("mid_rst_key_len",    32'(key_len),        32'd0);
      chk("mid_rst_din_ready",  32'(bus.din_ready),  32'd0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
